// File: rtl/curl_sponge_ctrl_pkg.sv
// Shared trit, sponge-state and controller-state types for the Curl-P sponge sequencer.
// All trits use the two-bit encoding with TRIT_ZERO as the all-zero code.
package curl_sponge_ctrl_pkg;

    localparam int TRIT_W      = 2;
    localparam int HASH_TRITS  = 243;
    localparam int STATE_TRITS = 729;

    typedef logic [TRIT_W-1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;

    typedef trit_t [STATE_TRITS-1:0] curl_state_t;
    typedef trit_t [HASH_TRITS-1:0]  curl_hash_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } curl_ctrl_state_e;

    localparam curl_state_t STATE_ZERO = {STATE_TRITS{TRIT_ZERO}};

    // Overwrites the rate part with a block; a fresh message also clears the capacity.
    function automatic curl_state_t absorb(input curl_state_t s,
                                           input curl_hash_t  blk,
                                           input logic        fresh);
        curl_state_t r;
        r = fresh ? STATE_ZERO : s;
        r[HASH_TRITS-1:0] = blk;
        return r;
    endfunction

endpackage

// File: rtl/curl_wdog.sv
// Loadable down-counter watchdog: expire_o is high while the count sits at zero.
// Decrements once per enabled cycle and holds at zero; load takes priority over enable.
module curl_wdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/curl_sponge_ctrl.sv
// Curl-P sponge sequencer: absorb a block, run one core transform, emit the hash after the last block.
// Block accept to core_start is one cycle; accepts nothing while a transform or hash is outstanding.
module curl_sponge_ctrl
    import curl_sponge_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            msg_valid,
    output logic                            msg_ready,
    input  logic [HASH_TRITS*TRIT_W-1:0]    msg_data,
    input  logic                            msg_last,
    output logic                            hash_valid,
    input  logic                            hash_ready,
    output logic [HASH_TRITS*TRIT_W-1:0]    hash_data,
    output logic                            core_start,
    output logic [STATE_TRITS*TRIT_W-1:0]   core_state_o,
    input  logic                            core_done,
    input  logic [STATE_TRITS*TRIT_W-1:0]   core_state_i,
    output logic                            busy,
    output logic                            err_timeout,
    output logic [CNT_W-1:0]                blk_cnt
);

    localparam bit WDOG_ON = (TIMEOUT_CYCLES != 0);
    localparam int WDOG_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LOAD =
        (TIMEOUT_CYCLES == 0) ? '0 : WDOG_W'(TIMEOUT_CYCLES - 1);

    curl_ctrl_state_e fsm_q, fsm_d;
    curl_state_t      state_q, state_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] blk_q, blk_d;

    logic wdog_load;
    logic wdog_en;
    logic wdog_expire;

    curl_wdog #(
        .W (WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wdog_load),
        .load_val_i (WDOG_LOAD),
        .en_i       (wdog_en),
        .expire_o   (wdog_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= STATE_ZERO;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            blk_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        first_d   = first_q;
        last_d    = last_q;
        err_d     = err_q;
        blk_d     = blk_q;
        wdog_load = 1'b0;
        wdog_en   = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (msg_valid) begin
                    state_d = absorb(state_q, curl_hash_t'(msg_data), first_q);
                    last_d  = msg_last;
                    blk_d   = first_q ? CNT_W'(1) : ((&blk_q) ? blk_q : blk_q + 1'b1);
                    first_d = 1'b0;
                    err_d   = 1'b0;
                    fsm_d   = START;
                end
            end
            START: begin
                wdog_load = 1'b1;
                fsm_d     = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still completes the block.
                if (core_done) begin
                    state_d = curl_state_t'(core_state_i);
                    fsm_d   = last_q ? OUT : IDLE;
                end else if (WDOG_ON && wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = STATE_ZERO;
                    first_d = 1'b1;
                    blk_d   = '0;
                    fsm_d   = IDLE;
                end else begin
                    wdog_en = 1'b1;
                end
            end
            OUT: begin
                if (hash_ready) begin
                    state_d = STATE_ZERO;
                    first_d = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign msg_ready    = (fsm_q == IDLE);
    assign core_start   = (fsm_q == START);
    assign hash_valid   = (fsm_q == OUT);
    assign busy         = (fsm_q != IDLE);
    assign hash_data    = state_q[HASH_TRITS-1:0];
    assign core_state_o = state_q;
    assign err_timeout  = err_q;
    assign blk_cnt      = blk_q;

endmodule

// File: tb/tb_curl_sponge_ctrl.sv
// Directed-plus-random bench for curl_sponge_ctrl with a trit-level sponge reference model
// and an in-bench core model (fixed-pattern or permute-and-add transform).
module tb_curl_sponge_ctrl;

    localparam int HW = 243 * 2;
    localparam int SW = 729 * 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          msg_valid;
    logic          msg_ready;
    logic [HW-1:0] msg_data;
    logic          msg_last;
    logic          hash_valid;
    logic          hash_ready;
    logic [HW-1:0] hash_data;
    logic          core_start;
    logic [SW-1:0] core_state_o;
    logic          core_done;
    logic [SW-1:0] core_state_i;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   blk_cnt;

    curl_sponge_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_data     (msg_data),
        .msg_last     (msg_last),
        .hash_valid   (hash_valid),
        .hash_ready   (hash_ready),
        .hash_data    (hash_data),
        .core_start   (core_start),
        .core_state_o (core_state_o),
        .core_done    (core_done),
        .core_state_i (core_state_i),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .blk_cnt      (blk_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_starts = 0;

    always @(negedge clk) if (core_start === 1'b1) n_starts++;

    // Reference sponge model
    logic [SW-1:0] m_state;
    bit            m_first;
    int            m_blk;
    bit            m_err;
    bit            core_fixed;
    logic [SW-1:0] core_pat;
    logic [SW-1:0] cap_in;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [HW-1:0] rand_blk();
        logic [HW-1:0] r;
        for (int i = 0; i < 243; i++) r[2*i +: 2] = 2'($urandom_range(2, 0));
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        for (int i = 0; i < 729; i++) r[2*i +: 2] = 2'($urandom_range(2, 0));
        return r;
    endfunction

    // Core transform: trit i takes trit (i+1) mod 729 plus i, modulo 3.
    function automatic logic [SW-1:0] xf(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        int v;
        for (int i = 0; i < 729; i++) begin
            v = int'(s[2*((i + 1) % 729) +: 2]);
            r[2*i +: 2] = 2'((v + i) % 3);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = '0;
        m_first = 1'b1;
        m_blk   = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   SW'(msg_ready),   SW'(1));
        check({tag, "_hv"},    SW'(hash_valid),  SW'(0));
        check({tag, "_start"}, SW'(core_start),  SW'(0));
        check({tag, "_busy"},  SW'(busy),        SW'(0));
        check({tag, "_err"},   SW'(err_timeout), SW'(0));
        check({tag, "_blk"},   SW'(blk_cnt),     SW'(0));
        check({tag, "_state"}, core_state_o,     SW'(0));
        check({tag, "_hash"},  SW'(hash_data),   SW'(0));
    endtask

    // Presents a block at a negedge in IDLE; returns at the negedge of the core_start cycle.
    task automatic accept_block(input logic [HW-1:0] d, input bit last, input bit hold_valid);
        check("acc_rdy", SW'(msg_ready), SW'(1));
        msg_valid = 1'b1;
        msg_data  = d;
        msg_last  = last;
        @(negedge clk);
        if (!hold_valid) msg_valid = 1'b0;
        if (m_first) m_state = '0;
        m_state[HW-1:0] = d;
        m_blk   = m_first ? 1 : ((m_blk == 65535) ? 65535 : m_blk + 1);
        m_first = 1'b0;
        m_err   = 1'b0;
        check("start_pulse", SW'(core_start),  SW'(1));
        check("start_state", core_state_o,     m_state);
        check("start_blk",   SW'(blk_cnt),     SW'(m_blk));
        check("start_err",   SW'(err_timeout), SW'(0));
        check("start_rdy",   SW'(msg_ready),   SW'(0));
        cap_in = core_state_o;
    endtask

    // Core model: done pulse lat cycles after core_start, then checks the controller's reaction.
    task automatic finish_block(input bit last, input int lat);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) check("wait_nostart", SW'(core_start), SW'(0));
        end
        check("wait_busy", SW'({busy, msg_ready, hash_valid}), SW'(3'b100));
        msg_valid    = 1'b0;
        core_done    = 1'b1;
        core_state_i = core_fixed ? core_pat : xf(cap_in);
        @(negedge clk);
        core_done    = 1'b0;
        core_state_i = rand_state();
        m_state = core_fixed ? core_pat : xf(m_state);
        check("done_err", SW'(err_timeout), SW'(0));
        if (last) begin
            check("out_hv",   SW'({hash_valid, msg_ready}), SW'(2'b10));
            check("out_hash", SW'(hash_data), SW'(m_state[HW-1:0]));
        end else begin
            check("next_rdy",   SW'({hash_valid, msg_ready}), SW'(2'b01));
            check("next_state", core_state_o, m_state);
        end
    endtask

    task automatic send_block(input logic [HW-1:0] d, input bit last, input int lat, input bit hold_valid);
        accept_block(d, last, hold_valid);
        finish_block(last, lat);
    endtask

    task automatic take_hash();
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        m_state = '0;
        m_first = 1'b1;
        check("post_hs", SW'({hash_valid, msg_ready, busy}), SW'(3'b010));
        check("post_hs_state", core_state_o, SW'(0));
    endtask

    initial begin
        int s0;
        int nb;
        rst          = 1'b1;
        msg_valid    = 1'b0;
        msg_data     = '0;
        msg_last     = 1'b0;
        hash_ready   = 1'b0;
        core_done    = 1'b0;
        core_state_i = '0;
        core_fixed   = 1'b0;
        core_pat     = '0;
        cap_in       = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // Single-block message, zero data, core returns a fixed pattern after 81 cycles
        core_fixed = 1'b1;
        core_pat   = rand_state();
        s0 = n_starts;
        send_block('0, 1'b1, 81, 1'b0);
        check("single_blk", SW'(blk_cnt), SW'(1));
        check("single_starts", SW'(n_starts - s0), SW'(1));
        take_hash();

        // Three-block message through the transform model
        core_fixed = 1'b0;
        s0 = n_starts;
        for (int b = 0; b < 3; b++) send_block(rand_blk(), b == 2, 5 + b, 1'b0);
        check("three_starts", SW'(n_starts - s0), SW'(3));
        check("three_blk", SW'(blk_cnt), SW'(3));
        take_hash();

        // Hash backpressure for 50 cycles
        send_block(rand_blk(), 1'b1, 7, 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("bp_ctl",  SW'({hash_valid, msg_ready, busy}), SW'(3'b101));
            check("bp_hash", SW'(hash_data), SW'(m_state[HW-1:0]));
        end
        take_hash();
        accept_block(rand_blk(), 1'b1, 1'b0);
        check("fresh_cap", SW'(cap_in[SW-1:HW]), SW'(0));
        finish_block(1'b1, 4);
        take_hash();

        // Watchdog expiry: core never answers
        accept_block(rand_blk(), 1'b1, 1'b0);
        repeat (256) @(negedge clk);
        check("wd_pre", SW'({busy, msg_ready, err_timeout}), SW'(3'b100));
        @(negedge clk);
        model_reset();
        m_err = 1'b1;
        check("wd_post", SW'({busy, msg_ready, err_timeout}), SW'(3'b011));
        check("wd_blk",   SW'(blk_cnt), SW'(0));
        check("wd_state", core_state_o, SW'(0));
        send_block(rand_blk(), 1'b0, 3, 1'b0);
        send_block(rand_blk(), 1'b1, 2, 1'b0);
        take_hash();

        // Done lands exactly on the expiry cycle: no error
        send_block(rand_blk(), 1'b1, 256, 1'b0);
        take_hash();

        // Reset while waiting, then a stale done
        accept_block(rand_blk(), 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_busy", SW'(busy), SW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        core_done    = 1'b1;
        core_state_i = rand_state();
        @(negedge clk);
        core_done = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check_reset_vals("stale");

        // Spurious done in IDLE, msg_valid held in WAIT, spurious done in OUT
        send_block(rand_blk(), 1'b0, 3, 1'b0);
        core_done    = 1'b1;
        core_state_i = rand_state();
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check("sp_idle_state", core_state_o, m_state);
        check("sp_idle_ctl", SW'({busy, msg_ready}), SW'(2'b01));
        s0 = n_starts;
        send_block(rand_blk(), 1'b1, 6, 1'b1);
        check("hold_starts", SW'(n_starts - s0), SW'(1));
        check("hold_blk", SW'(blk_cnt), SW'(2));
        core_done    = 1'b1;
        core_state_i = rand_state();
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check("sp_out_hv",   SW'(hash_valid), SW'(1));
        check("sp_out_hash", SW'(hash_data), SW'(m_state[HW-1:0]));
        take_hash();

        // Random messages
        for (int m = 0; m < 4; m++) begin
            nb = int'($urandom_range(4, 1));
            for (int b = 0; b < nb; b++)
                send_block(rand_blk(), b == nb - 1, int'($urandom_range(12, 1)), 1'b0);
            check("rnd_blk", SW'(blk_cnt), SW'(nb));
            take_hash();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/curl_sponge_ctrl.md
Name: curl_sponge_ctrl

Overview:
Sponge-mode sequencer for the Curl-P transform engine in curl_pkg.
- Owns the 729-trit sponge state and accepts 243-trit message blocks over a valid/ready stream.
- For each block: absorbs it into the state, launches one transform on the core, and captures the result.
- After the last block of a message, presents the 243-trit hash on an output valid/ready stream.
- Sits between the host/DMA trit stream and the curl transform core; includes a watchdog for a hung core.

Parameters:
- TRIT_W, 2: bits per trit, per trinary_pkg encoding.
- HASH_TRITS, 243: trits per block and per hash.
- STATE_TRITS, 729: sponge state trits.
- TIMEOUT_CYCLES, 256: maximum cycles in WAIT before abort; 0 disables the watchdog.
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- msg_valid  in  1  message block valid.
- msg_ready  out  1  controller can accept a block.
- msg_data  in  HASH_TRITS*TRIT_W  block trits; trit 0 in the LSBs.
- msg_last  in  1  block is the final block of the message.
- hash_valid  out  1  hash available.
- hash_ready  in  1  consumer accepts the hash.
- hash_data  out  HASH_TRITS*TRIT_W  state trits 0..242.
- core_start  out  1  one-cycle pulse launching a transform.
- core_state_o  out  STATE_TRITS*TRIT_W  state presented to the core; stable from START until done.
- core_done  in  1  one-cycle pulse; the core result is valid.
- core_state_i  in  STATE_TRITS*TRIT_W  transformed state from the core.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky watchdog error flag.
- blk_cnt  out  CNT_W  blocks absorbed in the current message; saturates.

Behaviour:
- Reset (async, active-high) values: state register all TRIT_ZERO, fsm=IDLE, first_r=1, last_r=0, wdog=0, msg_ready=1, hash_valid=0, core_start=0, busy=0, err_timeout=0, blk_cnt=0. hash_data and core_state_o reflect the zeroed state register.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE:
  - msg_ready=1; all other states drive msg_ready=0.
  - On msg_valid&&msg_ready: trits 0..242 <= msg_data. If first_r, trits 243..728 <= TRIT_ZERO; otherwise they are kept.
  - Also on accept: last_r <= msg_last; blk_cnt <= (first_r ? 1 : blk_cnt+1), saturating at all-ones; first_r <= 0; err_timeout <= 0; go to START.
- START:
  - core_start=1 for exactly one cycle; wdog <= 0; go to WAIT.
- WAIT:
  - core_done=1: state register <= core_state_i; go to OUT if last_r, else IDLE.
  - Otherwise wdog increments.
  - If TIMEOUT_CYCLES!=0 and wdog==TIMEOUT_CYCLES-1 without core_done: err_timeout <= 1; state <= TRIT_ZERO; first_r <= 1; blk_cnt <= 0; go to IDLE.
  - core_done in the same cycle as expiry: done wins, no error.
- OUT:
  - hash_valid=1; hash_data = state trits 0..242, held stable until the handshake.
  - On hash_ready: state <= TRIT_ZERO, first_r <= 1, go to IDLE.
  - hash_valid deasserts the cycle after the handshake.
- core_done outside WAIT is ignored, including a stale done arriving after reset.
- Latency: with accept at edge t, core_start is high in cycle t+1. With core latency L (core_done L cycles after core_start), hash_valid rises L+1 cycles after core_start for a last block. Next msg_ready for a non-last block follows the same timing.
- Throughput: one block per L+2 cycles; no overlap of absorb and transform.
- Reset mid-operation: returns to IDLE with a cleared state; no hash is emitted. A core transform still in flight is the core's concern, not the controller's.
- msg_last on the first block gives a single-block message. Zero-block messages are not supported.

Decomposition:
- curl_const_pkg holds HASH_TRITS, STATE_TRITS, TRIT_W and TRIT_ZERO (from trinary_pkg).
- curl_pkg gets:
  - a curl_ctrl_state_e enum {IDLE, START, WAIT, OUT};
  - a curl_state_t packed array of trit_t[STATE_TRITS];
  - a curl_hash_t packed array of trit_t[HASH_TRITS].
- Sub-module curl_wdog: a down-counter with load, enable and expire outputs, reusable by other engines.

Test Plan:
- Single-block message: msg_data all TRIT_ZERO with msg_last=1, core model of L=81 returning a fixed pattern P → core_start at t+1, hash_valid at t+83, hash_data=P[0..242], blk_cnt=1.
- Three-block message with a 3-block sequence and an echo+1 core model → exactly 3 core_start pulses.
  - core_state_o trits 243..728 on block 2 equal the core output of block 1.
  - blk_cnt reads 3 at OUT; hash matches the software Curl-P golden.
- Backpressure: hold hash_ready=0 for 50 cycles → hash_valid stays 1, hash_data stable, msg_ready=0.
  - After release, the next message starts from a zeroed state, so core_state_o trits 243..728 are all zero.
- Watchdog: core never asserts done, TIMEOUT_CYCLES=256 → err_timeout=1 and IDLE 256 cycles after WAIT entry.
  - The next accepted block clears err_timeout. A done on the expiry cycle gives no error.
- Async reset asserted in WAIT, then a stale core_done pulsed after release → all outputs at reset values, no hash_valid, stale done ignored.
- Spurious core_done in IDLE and OUT, and msg_valid held high during WAIT → no state change; no extra block accepted (msg_ready=0).
